// File: rtl/line_load_sequencer_pkg.sv
// Shared definitions for the SLM line-load path: sequencer state encoding,
// panel geometry and counter widths used by sequencer, timing and line clocking.
package line_load_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FILL      = 3'd1,
    ST_HANDOFF   = 3'd2,
    ST_WAIT_LINE = 3'd3,
    ST_UPDATE    = 3'd4
  } seq_state_e;

  localparam int SLM_WORDS_PER_LINE  = 40;
  localparam int SLM_LINES_PER_FRAME = 1024;

  localparam int WORD_CNT_W = 7;
  localparam int LINE_CNT_W = 11;

  // Stall counter must be able to hold the limit itself so it can saturate there.
  function automatic int stall_cnt_width(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/line_load_sequencer_stall_watchdog.sv
// Flags a FIFO underrun once the FIFO has stayed empty for STALL_LIMIT
// consecutive cycles while the sequencer is trying to fill a line.
module stall_watchdog
  import line_load_sequencer_pkg::*;
#(
  parameter int STALL_LIMIT = 4096
) (
  input  logic fpga_clk,
  input  logic reset_all,
  input  logic active,
  input  logic empty,
  input  logic accept,
  output logic underrun
);

  localparam int CNT_W = stall_cnt_width(STALL_LIMIT);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STALL_LIMIT);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             flag_q, flag_d;

  always_comb begin
    cnt_d  = cnt_q;
    flag_d = flag_q;
    if (!active || accept) begin
      cnt_d = '0;
    end else if (empty && (cnt_q < LIMIT)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    // Sticky: only reset_all clears the flag, sequencing carries on regardless.
    if (cnt_d == LIMIT) begin
      flag_d = 1'b1;
    end
  end

  always_ff @(posedge fpga_clk) begin
    if (reset_all) begin
      cnt_q  <= '0;
      flag_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      flag_q <= flag_d;
    end
  end

  assign underrun = flag_q;

endmodule

// File: rtl/line_load_sequencer.sv
// Moves SLM frame data from the dc32 FIFO into the line buffer one line at a
// time, hands each line to the line clocker and pulses update at frame end.
module line_load_sequencer
  import line_load_sequencer_pkg::*;
#(
  parameter int WORDS_PER_LINE  = SLM_WORDS_PER_LINE,
  parameter int LINES_PER_FRAME = SLM_LINES_PER_FRAME,
  parameter int UPDATE_CYCLES   = 8,
  parameter int STALL_LIMIT     = 4096
) (
  input  logic                  fpga_clk,
  input  logic                  reset_all,
  input  logic                  enable,
  input  logic                  dc32_fifo_is_empty,
  output logic                  dc32_fifo_read_en,
  output logic [WORD_CNT_W-1:0] num_words_in_buffer,
  output logic                  start_clocking_line,
  input  logic                  line_clock_done,
  output logic [LINE_CNT_W-1:0] line_index,
  output logic                  update,
  output logic                  invert,
  output logic                  frame_done,
  output logic                  underrun,
  output logic                  busy
);

  localparam int UPD_W = (UPDATE_CYCLES > 1) ? $clog2(UPDATE_CYCLES) : 1;
  localparam logic [WORD_CNT_W-1:0] WORDS_FULL = WORD_CNT_W'(WORDS_PER_LINE);
  localparam logic [LINE_CNT_W-1:0] LINE_LAST  = LINE_CNT_W'(LINES_PER_FRAME - 1);
  localparam logic [UPD_W-1:0]      UPD_LAST   = UPD_W'(UPDATE_CYCLES - 1);

  seq_state_e            state_q, state_d;
  logic [WORD_CNT_W-1:0] word_q, word_d;
  logic [LINE_CNT_W-1:0] line_q, line_d;
  logic [UPD_W-1:0]      upd_q, upd_d;
  logic                  invert_q, invert_d;
  logic                  busy_q, busy_d;
  logic                  read_en;

  always_comb begin
    state_d  = state_q;
    word_d   = word_q;
    line_d   = line_q;
    upd_d    = upd_q;
    invert_d = invert_q;
    read_en  = (state_q == ST_FILL) && !dc32_fifo_is_empty && (word_q < WORDS_FULL);
    unique case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d = ST_FILL;
          line_d  = '0;
          word_d  = '0;
        end
      end
      ST_FILL: begin
        if (read_en) begin
          word_d = word_q + WORD_CNT_W'(1);
        end
        if (word_d == WORDS_FULL) begin
          state_d = ST_HANDOFF;
        end
      end
      ST_HANDOFF: begin
        state_d = ST_WAIT_LINE;
      end
      ST_WAIT_LINE: begin
        if (line_clock_done) begin
          word_d = '0;
          if (line_q == LINE_LAST) begin
            state_d = ST_UPDATE;
          end else begin
            line_d  = line_q + LINE_CNT_W'(1);
            state_d = ST_FILL;
          end
        end
      end
      ST_UPDATE: begin
        // enable is only consulted here, so a started frame always completes.
        if (upd_q == UPD_LAST) begin
          upd_d    = '0;
          invert_d = ~invert_q;
          line_d   = '0;
          state_d  = enable ? ST_FILL : ST_IDLE;
        end else begin
          upd_d = upd_q + UPD_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge fpga_clk) begin
    if (reset_all) begin
      state_q  <= ST_IDLE;
      word_q   <= '0;
      line_q   <= '0;
      upd_q    <= '0;
      invert_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      word_q   <= word_d;
      line_q   <= line_d;
      upd_q    <= upd_d;
      invert_q <= invert_d;
      busy_q   <= busy_d;
    end
  end

  stall_watchdog #(
    .STALL_LIMIT(STALL_LIMIT)
  ) u_stall_watchdog (
    .fpga_clk (fpga_clk),
    .reset_all(reset_all),
    .active   (state_q == ST_FILL),
    .empty    (dc32_fifo_is_empty),
    .accept   (read_en),
    .underrun (underrun)
  );

  assign dc32_fifo_read_en   = read_en;
  assign num_words_in_buffer = word_q;
  assign start_clocking_line = (state_q == ST_HANDOFF);
  assign line_index          = line_q;
  assign update              = (state_q == ST_UPDATE);
  assign frame_done          = (state_q == ST_UPDATE) && (upd_q == UPD_LAST);
  assign invert              = invert_q;
  assign busy                = busy_q;

endmodule

// File: tb/tb_line_load_sequencer.sv
// Self-checking bench for line_load_sequencer: directed scenarios plus a
// randomized run, all compared cycle by cycle against a frame/line level model.
module tb_line_load_sequencer;

  localparam int WPL = 4;
  localparam int LPF = 3;
  localparam int UC  = 2;
  localparam int SL  = 8;

  logic        fpga_clk = 1'b0;
  logic        reset_all = 1'b1;
  logic        enable = 1'b0;
  logic        dc32_fifo_is_empty = 1'b1;
  logic        dc32_fifo_read_en;
  logic [6:0]  num_words_in_buffer;
  logic        start_clocking_line;
  logic        line_clock_done = 1'b0;
  logic [10:0] line_index;
  logic        update;
  logic        invert;
  logic        frame_done;
  logic        underrun;
  logic        busy;

  int checkCount = 0;
  int failCount  = 0;
  int cycleCount = 0;
  int doneCnt    = 0;
  bit chaosEn    = 1'b1;

  // Reference model: a frame is "running"; inside it we either play out the
  // update pulse, load words, announce a full line once, or wait for the clocker.
  bit mRunning, mHandoff, mInvert, mUnderrun;
  int mLine, mWords, mUpdLeft, mStall;

  line_load_sequencer #(
    .WORDS_PER_LINE (WPL),
    .LINES_PER_FRAME(LPF),
    .UPDATE_CYCLES  (UC),
    .STALL_LIMIT    (SL)
  ) dut (
    .fpga_clk           (fpga_clk),
    .reset_all          (reset_all),
    .enable             (enable),
    .dc32_fifo_is_empty (dc32_fifo_is_empty),
    .dc32_fifo_read_en  (dc32_fifo_read_en),
    .num_words_in_buffer(num_words_in_buffer),
    .start_clocking_line(start_clocking_line),
    .line_clock_done    (line_clock_done),
    .line_index         (line_index),
    .update             (update),
    .invert             (invert),
    .frame_done         (frame_done),
    .underrun           (underrun),
    .busy               (busy)
  );

  always #5 fpga_clk = ~fpga_clk;

  function automatic bit mFill();
    return mRunning && (mUpdLeft == 0) && (mWords < WPL);
  endfunction

  function automatic bit mStart();
    return mRunning && (mUpdLeft == 0) && (mWords == WPL) && mHandoff;
  endfunction

  function automatic bit mWaiting();
    return mRunning && (mUpdLeft == 0) && (mWords == WPL) && !mHandoff;
  endfunction

  task automatic modelReset();
    mRunning = 0; mHandoff = 0; mInvert = 0; mUnderrun = 0;
    mLine = 0; mWords = 0; mUpdLeft = 0; mStall = 0;
  endtask

  // Advance the model by one clock edge given the inputs seen in that cycle.
  task automatic modelStep(input bit rst, input bit en, input bit emp, input bit done);
    if (rst) begin
      modelReset();
    end else if (!mRunning) begin
      mStall = 0;
      if (en) begin
        mRunning = 1; mLine = 0; mWords = 0; mHandoff = 0;
      end
    end else if (mUpdLeft > 0) begin
      mStall = 0;
      mUpdLeft--;
      if (mUpdLeft == 0) begin
        mInvert = !mInvert;
        mLine = 0;
        mWords = 0;
        if (!en) mRunning = 0;
      end
    end else if (mFill()) begin
      if (!emp) begin
        mWords++;
        mStall = 0;
        if (mWords == WPL) mHandoff = 1;
      end else begin
        mStall++;
        if (mStall >= SL) mUnderrun = 1;
      end
    end else if (mStart()) begin
      mHandoff = 0;
      mStall = 0;
    end else begin
      mStall = 0;
      if (done) begin
        mWords = 0;
        if (mLine == LPF - 1) mUpdLeft = UC;
        else mLine++;
      end
    end
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] actual, input logic [15:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      if (failCount <= 40)
        $display("[TB] FAIL %s cycle=%0d got=%0d expected=%0d", tag, cycleCount, actual, expected);
    end
  endtask

  // One clock: drive inputs on the falling edge, compare just after, step on the rising edge.
  task automatic stepCycle(input bit rst, input bit en, input bit emp, input bit done);
    @(negedge fpga_clk);
    reset_all          = rst;
    enable             = en;
    dc32_fifo_is_empty = emp;
    line_clock_done    = done;
    #1;
    checkOutput("read_en",   16'(dc32_fifo_read_en),   16'(mFill() && !emp));
    checkOutput("num_words", 16'(num_words_in_buffer), 16'(mWords));
    checkOutput("start",     16'(start_clocking_line), 16'(mStart()));
    checkOutput("line_idx",  16'(line_index),          16'(mLine));
    checkOutput("update",    16'(update),              16'(mUpdLeft > 0));
    checkOutput("frame_done",16'(frame_done),          16'(mUpdLeft == 1));
    checkOutput("invert",    16'(invert),              16'(mInvert));
    checkOutput("underrun",  16'(underrun),            16'(mUnderrun));
    checkOutput("busy",      16'(busy),                16'(mRunning));
    @(posedge fpga_clk);
    modelStep(rst, en, emp, done);
    cycleCount++;
  endtask

  // emptyMode: 0 never empty, 1 alternate, 2 random, 3 always empty.
  // The clocker answers doneDelay cycles after each start; chaos adds random
  // resets, enable flips and stray done pulses.
  task automatic applyStimulus(input int cycles, input int emptyMode, input bit en,
                               input int doneDelay, input bit chaos);
    for (int i = 0; i < cycles; i++) begin
      bit emp, dn, rst, e;
      e = en; rst = 0; dn = 0;
      case (emptyMode)
        0:       emp = 0;
        1:       emp = cycleCount[0];
        2:       emp = ($urandom_range(99) < 30);
        default: emp = 1;
      endcase
      if (doneCnt > 0) begin
        doneCnt--;
        dn = (doneCnt == 0);
      end
      if (chaos) begin
        if ($urandom_range(199) == 0) rst = 1;
        if ($urandom_range(99) < 3) dn = 1;
        if ($urandom_range(59) == 0) chaosEn = !chaosEn;
        e = chaosEn;
      end
      if (mStart()) doneCnt = chaos ? int'($urandom_range(5, 1)) : doneDelay;
      stepCycle(rst, e, emp, dn);
    end
  endtask

  // Run a normal frame until the model reaches line 1 (which=1) or a wait (which=2).
  task automatic runUntil(input int which, input string tag);
    bit reached = 0;
    for (int i = 0; i < 200 && !reached; i++) begin
      applyStimulus(1, 0, 1'b1, 3, 1'b0);
      reached = (which == 1) ? (mLine == 1 && mFill()) : mWaiting();
    end
    checkOutput(tag, 16'(reached), 16'd1);
  endtask

  task automatic doReset();
    doneCnt = 0;
    stepCycle(1'b1, 1'b0, 1'b1, 1'b0);
    stepCycle(1'b1, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    modelReset();
    doReset();
    #2;
    checkOutput("rst_busy",   16'(busy), 16'd0);
    checkOutput("rst_invert", 16'(invert), 16'd0);

    // Full frames with a FIFO that never runs dry.
    applyStimulus(60, 0, 1'b1, 3, 1'b0);

    // FIFO empty every other cycle.
    doReset();
    applyStimulus(40, 1, 1'b1, 3, 1'b0);
    #2;
    checkOutput("alt_underrun", 16'(underrun), 16'd0);

    // FIFO dry long enough to trip the watchdog, then refills.
    doReset();
    applyStimulus(1, 3, 1'b1, 3, 1'b0);
    applyStimulus(12, 3, 1'b1, 3, 1'b0);
    applyStimulus(40, 0, 1'b1, 3, 1'b0);
    #2;
    checkOutput("stall_underrun", 16'(underrun), 16'd1);
    doReset();
    #2;
    checkOutput("underrun_cleared", 16'(underrun), 16'd0);

    // enable dropped on line 1: frame completes, then idle; re-enable runs on.
    runUntil(1, "reach_line1");
    applyStimulus(60, 0, 1'b0, 3, 1'b0);
    #2;
    checkOutput("drop_busy",   16'(busy), 16'd0);
    checkOutput("drop_invert", 16'(invert), 16'd1);
    applyStimulus(40, 0, 1'b1, 3, 1'b0);
    #2;
    checkOutput("reen_invert", 16'(invert), 16'd0);

    // reset while waiting on the clocker; a late done pulse must be ignored.
    doReset();
    runUntil(2, "reach_wait");
    stepCycle(1'b1, 1'b1, 1'b0, 1'b0);
    doneCnt = 0;
    stepCycle(1'b0, 1'b0, 1'b0, 1'b1);
    #2;
    checkOutput("late_busy",   16'(busy), 16'd0);
    checkOutput("late_update", 16'(update), 16'd0);
    applyStimulus(5, 0, 1'b0, 3, 1'b0);

    // Randomized traffic.
    doReset();
    applyStimulus(3000, 2, 1'b1, 3, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
